// File: rtl/vid_seq_pkg.sv
// rtl/vid_seq_pkg.sv - shared SEW codes, sequencer state and beat-geometry helper
package vid_seq_pkg;

  localparam logic [2:0] SEW_8  = 3'd0;
  localparam logic [2:0] SEW_16 = 3'd1;
  localparam logic [2:0] SEW_32 = 3'd2;
  localparam logic [2:0] SEW_64 = 3'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  // log2(elements per beat); illegal SEW codes map to 0 and never issue beats
  function automatic logic [4:0] log_epb(input logic [2:0] sew, input int byte_en_width);
    int lg = $clog2(byte_en_width);
    case (sew)
      SEW_8:   return 5'(lg);
      SEW_16:  return 5'(lg - 1);
      SEW_32:  return 5'(lg - 2);
      SEW_64:  return 5'(lg - 3);
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/vid_seq_mask.sv
// rtl/vid_seq_mask.sv - combinational active-element mask for one beat
module vid_seq_mask
  import vid_seq_pkg::*;
#(
  parameter int REQ_BYTE_EN_WIDTH = 8,
  parameter int VL_WIDTH          = 16
) (
  input  logic [VL_WIDTH:0]          i_beat,
  input  logic [VL_WIDTH-1:0]        i_vstart,
  input  logic [VL_WIDTH-1:0]        i_vl,
  input  logic [2:0]                 i_sew,
  output logic [REQ_BYTE_EN_WIDTH-1:0] o_mask
);

  logic [4:0]        w_log_epb;
  logic [VL_WIDTH:0] w_base;

  assign w_log_epb = log_epb(i_sew, REQ_BYTE_EN_WIDTH);
  assign w_base    = i_beat << w_log_epb;

  always_comb begin
    logic [VL_WIDTH:0] elem;
    elem   = '0;
    o_mask = '0;
    for (int i = 0; i < REQ_BYTE_EN_WIDTH; i++) begin
      elem = w_base + (VL_WIDTH+1)'(i);
      if ((i < (1 << w_log_epb)) && (elem >= {1'b0, i_vstart}) && (elem < {1'b0, i_vl}))
        o_mask[i] = 1'b1;
    end
  end

endmodule

// File: rtl/vid_seq.sv
// rtl/vid_seq.sv - splits one vid.v request into registered datapath beats
// Optional: VID_SEQ_BACKPRESSURE_EN lets out_ready stall beat advance.
module vid_seq
  import vid_seq_pkg::*;
#(
  parameter int REQ_BYTE_EN_WIDTH = 8,
  parameter int REQ_ADDR_WIDTH    = 32,
  parameter int VL_WIDTH          = 16,
  parameter int IDX_WIDTH         = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [REQ_ADDR_WIDTH-1:0]    req_addr,
  input  logic [2:0]                   req_sew,
  input  logic [VL_WIDTH-1:0]          req_vl,
  input  logic [VL_WIDTH-1:0]          req_vstart,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [REQ_ADDR_WIDTH-1:0]    out_addr,
  output logic [2:0]                   out_sew,
  output logic [IDX_WIDTH-1:0]         out_start_idx,
  output logic [REQ_BYTE_EN_WIDTH-1:0] out_mask,
  output logic                         out_last
);

  seq_state_t r_state, w_state_nxt;

  logic [REQ_ADDR_WIDTH-1:0]    r_addr;
  logic [2:0]                   r_sew;
  logic [VL_WIDTH-1:0]          r_vl, r_vstart;
  logic [VL_WIDTH:0]            r_beat, w_beat_nxt;
  logic [REQ_ADDR_WIDTH-1:0]    r_out_addr, w_out_addr_nxt;
  logic [IDX_WIDTH-1:0]         r_out_idx, w_out_idx_nxt;
  logic [REQ_BYTE_EN_WIDTH-1:0] r_out_mask, w_out_mask_nxt, w_mask;
  logic                         r_out_last, w_out_last_nxt;

  logic                         w_accept, w_has_beats, w_transfer;
  logic [REQ_ADDR_WIDTH-1:0]    w_addr;
  logic [2:0]                   w_sew;
  logic [VL_WIDTH-1:0]          w_vl, w_vstart;
  logic [4:0]                   w_log_epb;
  logic [VL_WIDTH:0]            w_first_beat, w_last_beat;

  // Geometry comes from the live request while idle and from the latch while running
  assign w_addr   = (r_state == ST_IDLE) ? req_addr   : r_addr;
  assign w_sew    = (r_state == ST_IDLE) ? req_sew    : r_sew;
  assign w_vl     = (r_state == ST_IDLE) ? req_vl     : r_vl;
  assign w_vstart = (r_state == ST_IDLE) ? req_vstart : r_vstart;

  assign w_log_epb    = log_epb(w_sew, REQ_BYTE_EN_WIDTH);
  assign w_first_beat = {1'b0, w_vstart} >> w_log_epb;
  assign w_last_beat  = ({1'b0, w_vl} - (VL_WIDTH+1)'(1)) >> w_log_epb;
  assign w_has_beats  = (w_vl != '0) && (w_vstart < w_vl) && (w_sew <= SEW_64);
  assign w_accept     = req_valid && (r_state == ST_IDLE);

`ifdef VID_SEQ_BACKPRESSURE_EN
  assign w_transfer = (r_state == ST_RUN) && out_ready;
`else
  logic w_unused_out_ready;
  assign w_unused_out_ready = out_ready;
  assign w_transfer         = (r_state == ST_RUN);
`endif

  vid_seq_mask #(
    .REQ_BYTE_EN_WIDTH(REQ_BYTE_EN_WIDTH),
    .VL_WIDTH         (VL_WIDTH)
  ) u_mask (
    .i_beat  (w_beat_nxt),
    .i_vstart(w_vstart),
    .i_vl    (w_vl),
    .i_sew   (w_sew),
    .o_mask  (w_mask)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_has_beats) begin
          w_state_nxt = ST_RUN;
          w_beat_nxt  = w_first_beat;
        end
      end
      ST_RUN: begin
        if (w_transfer) begin
          if (r_beat == w_last_beat) w_state_nxt = ST_IDLE;
          else                       w_beat_nxt  = r_beat + (VL_WIDTH+1)'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next-beat outputs; a stalled beat recomputes to identical values
  always_comb begin
    w_out_addr_nxt = '0;
    w_out_idx_nxt  = '0;
    w_out_mask_nxt = '0;
    w_out_last_nxt = 1'b0;
    if (w_state_nxt == ST_RUN) begin
      w_out_addr_nxt = w_addr + REQ_ADDR_WIDTH'(w_beat_nxt);
      w_out_idx_nxt  = IDX_WIDTH'(w_beat_nxt << w_log_epb);
      w_out_mask_nxt = w_mask;
      w_out_last_nxt = (w_beat_nxt == w_last_beat);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_sew      <= '0;
      r_vl       <= '0;
      r_vstart   <= '0;
      r_beat     <= '0;
      r_out_addr <= '0;
      r_out_idx  <= '0;
      r_out_mask <= '0;
      r_out_last <= 1'b0;
    end else begin
      if (w_accept && w_has_beats) begin
        r_addr   <= req_addr;
        r_sew    <= req_sew;
        r_vl     <= req_vl;
        r_vstart <= req_vstart;
      end
      r_beat     <= w_beat_nxt;
      r_out_addr <= w_out_addr_nxt;
      r_out_idx  <= w_out_idx_nxt;
      r_out_mask <= w_out_mask_nxt;
      r_out_last <= w_out_last_nxt;
    end
  end

  assign req_ready     = (r_state == ST_IDLE);
  assign out_valid     = (r_state == ST_RUN);
  assign out_addr      = r_out_addr;
  assign out_sew       = r_sew;
  assign out_start_idx = r_out_idx;
  assign out_mask      = r_out_mask;
  assign out_last      = r_out_last;

endmodule

// File: tb/tb_vid_seq.sv
// tb/tb_vid_seq.sv - directed self-checking bench for vid_seq
// Stall scenario is built only when VID_SEQ_BACKPRESSURE_EN is defined.
module tb_vid_seq;

  localparam int BW = 8;
  localparam int AW = 32;
  localparam int VW = 16;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [2:0]    req_sew = '0;
  logic [VW-1:0] req_vl = '0;
  logic [VW-1:0] req_vstart = '0;
  logic          out_ready = 1'b1;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [2:0]    out_sew;
  logic [IW-1:0] out_start_idx;
  logic [BW-1:0] out_mask;
  logic          out_last;

  int errors = 0;
  int checks = 0;

  // {valid, addr, start_idx, mask, last}
  logic [44:0] w_obs;
  assign w_obs = {out_valid, out_addr, out_start_idx, out_mask, out_last};

  always #5 clk = ~clk;

  vid_seq #(
    .REQ_BYTE_EN_WIDTH(BW),
    .REQ_ADDR_WIDTH   (AW),
    .VL_WIDTH         (VW),
    .IDX_WIDTH        (IW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_sew      (req_sew),
    .req_vl       (req_vl),
    .req_vstart   (req_vstart),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_addr     (out_addr),
    .out_sew      (out_sew),
    .out_start_idx(out_start_idx),
    .out_mask     (out_mask),
    .out_last     (out_last)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for one edge; returns with the first beat visible
  task automatic issue(input logic [AW-1:0] a, input logic [2:0] s,
                       input logic [VW-1:0] vl, input logic [VW-1:0] vs);
    req_addr = a; req_sew = s; req_vl = vl; req_vstart = vs; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (w_obs !== 45'd0) begin errors++; $display("FAIL reset_outputs: got %h want %h", w_obs, 45'd0); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    checks++; if (out_sew !== 3'd0) begin errors++; $display("FAIL reset_sew: got %0d want 0", out_sew); end
    rst = 1'b0;
    step();
    checks++; if (w_obs !== 45'd0 || req_ready !== 1'b1) begin errors++; $display("FAIL reset_idle: got %h/%b want 0/1", w_obs, req_ready); end
  endtask

  task automatic test_sew8();
    logic [44:0] exp [3];
    exp[0] = {1'b1, 32'h100, 3'd0, 8'hFF, 1'b0};
    exp[1] = {1'b1, 32'h101, 3'd0, 8'hFF, 1'b0};
    exp[2] = {1'b1, 32'h102, 3'd0, 8'h0F, 1'b1};
    issue(32'h100, 3'd0, 16'd20, 16'd0);
    for (int b = 0; b < 3; b++) begin
      checks++; if (w_obs !== exp[b]) begin errors++; $display("FAIL sew8_beat%0d: got %h want %h", b, w_obs, exp[b]); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL sew8_ready%0d: got %b want 0", b, req_ready); end
      if (b < 2) step();
    end
    checks++; if (out_sew !== 3'd0) begin errors++; $display("FAIL sew8_sew: got %0d want 0", out_sew); end
    step();
    checks++; if (w_obs !== 45'd0 || req_ready !== 1'b1) begin errors++; $display("FAIL sew8_done: got %h/%b want 0/1", w_obs, req_ready); end
  endtask

  task automatic test_sew32_vstart();
    logic [44:0] exp [2];
    exp[0] = {1'b1, 32'h41, 3'd2, 8'h02, 1'b0};
    exp[1] = {1'b1, 32'h42, 3'd4, 8'h01, 1'b1};
    issue(32'h40, 3'd2, 16'd5, 16'd3);
    for (int b = 0; b < 2; b++) begin
      checks++; if (w_obs !== exp[b]) begin errors++; $display("FAIL sew32_beat%0d: got %h want %h", b, w_obs, exp[b]); end
      if (b < 1) step();
    end
    checks++; if (out_sew !== 3'd2) begin errors++; $display("FAIL sew32_sew: got %0d want 2", out_sew); end
    step();
    checks++; if (w_obs !== 45'd0 || req_ready !== 1'b1) begin errors++; $display("FAIL sew32_done: got %h/%b want 0/1", w_obs, req_ready); end
  endtask

  task automatic test_no_beat();
    logic [2:0]    s  [3];
    logic [VW-1:0] vl [3];
    logic [VW-1:0] vs [3];
    s[0] = 3'd0; vl[0] = 16'd0; vs[0] = 16'd0;
    s[1] = 3'd0; vl[1] = 16'd9; vs[1] = 16'd9;
    s[2] = 3'd5; vl[2] = 16'd5; vs[2] = 16'd0;
    for (int k = 0; k < 3; k++) begin
      issue(32'h700, s[k], vl[k], vs[k]);
      checks++; if (out_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL nobeat%0d_accept: got valid=%b ready=%b want 0/1", k, out_valid, req_ready); end
      step();
      checks++; if (w_obs !== 45'd0) begin errors++; $display("FAIL nobeat%0d_quiet: got %h want 0", k, w_obs); end
    end
  endtask

`ifdef VID_SEQ_BACKPRESSURE_EN
  task automatic test_backpressure();
    logic [44:0] b0, b1, b2;
    b0 = {1'b1, 32'h80, 3'd0, 8'h01, 1'b0};
    b1 = {1'b1, 32'h81, 3'd1, 8'h01, 1'b0};
    b2 = {1'b1, 32'h82, 3'd2, 8'h01, 1'b1};
    out_ready = 1'b1;
    issue(32'h80, 3'd3, 16'd3, 16'd0);
    checks++; if (w_obs !== b0) begin errors++; $display("FAIL bp_beat0: got %h want %h", w_obs, b0); end
    step();
    out_ready = 1'b0;
    checks++; if (w_obs !== b1) begin errors++; $display("FAIL bp_beat1: got %h want %h", w_obs, b1); end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (w_obs !== b1 || req_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d: got %h/%b want %h/0", c, w_obs, req_ready, b1); end
    end
    out_ready = 1'b1;
    step();
    checks++; if (w_obs !== b2 || req_ready !== 1'b0) begin errors++; $display("FAIL bp_beat2: got %h/%b want %h/0", w_obs, req_ready, b2); end
    step();
    checks++; if (w_obs !== 45'd0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_done: got %h/%b want 0/1", w_obs, req_ready); end
  endtask
`else
  task automatic test_ignore_ready();
    logic [44:0] b0, b1;
    b0 = {1'b1, 32'h50, 3'd0, 8'h0F, 1'b0};
    b1 = {1'b1, 32'h51, 3'd4, 8'h0F, 1'b1};
    out_ready = 1'b0;
    issue(32'h50, 3'd1, 16'd8, 16'd0);
    checks++; if (w_obs !== b0) begin errors++; $display("FAIL noready_beat0: got %h want %h", w_obs, b0); end
    step();
    checks++; if (w_obs !== b1) begin errors++; $display("FAIL noready_beat1: got %h want %h", w_obs, b1); end
    step();
    checks++; if (w_obs !== 45'd0 || req_ready !== 1'b1) begin errors++; $display("FAIL noready_done: got %h/%b want 0/1", w_obs, req_ready); end
    out_ready = 1'b1;
  endtask
`endif

  task automatic test_reset_mid();
    logic [44:0] b0, b1, n0;
    b0 = {1'b1, 32'h200, 3'd0, 8'h0F, 1'b0};
    b1 = {1'b1, 32'h201, 3'd4, 8'h0F, 1'b0};
    n0 = {1'b1, 32'h301, 3'd1, 8'h01, 1'b1};
    issue(32'h200, 3'd1, 16'd32, 16'd0);
    checks++; if (w_obs !== b0) begin errors++; $display("FAIL rstmid_beat0: got %h want %h", w_obs, b0); end
    step();
    checks++; if (w_obs !== b1) begin errors++; $display("FAIL rstmid_beat1: got %h want %h", w_obs, b1); end
    #1 rst = 1'b1;
    #1;
    checks++; if (w_obs !== 45'd0 || req_ready !== 1'b1 || out_sew !== 3'd0) begin errors++; $display("FAIL rstmid_async: got %h/%b/%0d want 0/1/0", w_obs, req_ready, out_sew); end
    rst = 1'b0;
    step();
    checks++; if (w_obs !== 45'd0 || req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_idle: got %h/%b want 0/1", w_obs, req_ready); end
    issue(32'h300, 3'd3, 16'd2, 16'd1);
    checks++; if (w_obs !== n0 || out_sew !== 3'd3) begin errors++; $display("FAIL rstmid_newreq: got %h/%0d want %h/3", w_obs, out_sew, n0); end
    step();
    checks++; if (w_obs !== 45'd0 || req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_done: got %h/%b want 0/1", w_obs, req_ready); end
  endtask

  task automatic test_back_to_back();
    logic [44:0] exp [6];
    logic        rdy [6];
    exp[0] = {1'b1, 32'h10, 3'd0, 8'h0F, 1'b0}; rdy[0] = 1'b0;
    exp[1] = {1'b1, 32'h11, 3'd4, 8'h0F, 1'b1}; rdy[1] = 1'b0;
    exp[2] = 45'd0;                             rdy[2] = 1'b1;
    exp[3] = {1'b1, 32'h20, 3'd0, 8'h01, 1'b0}; rdy[3] = 1'b0;
    exp[4] = {1'b1, 32'h21, 3'd1, 8'h01, 1'b1}; rdy[4] = 1'b0;
    exp[5] = 45'd0;                             rdy[5] = 1'b1;
    req_addr = 32'h10; req_sew = 3'd1; req_vl = 16'd8; req_vstart = 16'd0; req_valid = 1'b1;
    step();
    req_addr = 32'h20; req_sew = 3'd3; req_vl = 16'd2; req_vstart = 16'd0;
    for (int k = 0; k < 6; k++) begin
      checks++; if (w_obs !== exp[k] || req_ready !== rdy[k]) begin errors++; $display("FAIL b2b_cycle%0d: got %h/%b want %h/%b", k, w_obs, req_ready, exp[k], rdy[k]); end
      if (k == 3) req_valid = 1'b0;
      if (k < 5) step();
    end
  endtask

  initial begin
    test_reset();
    test_sew8();
    test_sew32_vstart();
    test_no_beat();
`ifdef VID_SEQ_BACKPRESSURE_EN
    test_backpressure();
`else
    test_ignore_ready();
`endif
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
